// File: rtl/wide_op_sequencer.sv
// rtl/wide_op_sequencer.sv - byte-serial sequencer driving an 8-bit ALU for NBYTES-wide ops
// Optional feature macro: WIDE_OP_ZERO_FLAG_EN (adds rsp_zero output)
// Opcodes: kAdd=0 kAddC=1 kSub=2 kAnd=3 kOr=4 kNeg=5 kSll=6 kSra=7
module wide_op_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_err,
`ifdef WIDE_OP_ZERO_FLAG_EN
    output logic                  rsp_zero,
`endif
    output logic [3:0]            alu_ctrl,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_cin,
    input  logic [7:0]            alu_out,
    input  logic                  alu_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [3:0] K_ADD  = 4'h0;
    localparam logic [3:0] K_ADDC = 4'h1;
    localparam logic [3:0] K_SUB  = 4'h2;
    localparam logic [3:0] K_AND  = 4'h3;
    localparam logic [3:0] K_OR   = 4'h4;
    localparam logic [3:0] K_NEG  = 4'h5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;
`ifdef WIDE_OP_ZERO_FLAG_EN
    logic          zero_q, zero_d;
`endif

    logic [IW+2:0] bit_off;
    logic          req_supported;
    logic          op_is_arith;

    assign bit_off       = {idx_q, 3'b000};
    assign req_supported = (req_op == K_ADD) || (req_op == K_SUB) || (req_op == K_AND) ||
                           (req_op == K_OR)  || (req_op == K_NEG);
    assign op_is_arith   = (op_q == K_ADD) || (op_q == K_SUB);

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_data  = res_q;
    assign rsp_cout  = carry_q;
    assign rsp_err   = err_q;
`ifdef WIDE_OP_ZERO_FLAG_EN
    assign rsp_zero  = zero_q;
`endif

    // Present the current byte to the ALU in RUN; park it on a zero-producing AND otherwise
    always_comb begin
        alu_ctrl = K_AND;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_cin  = 1'b0;
        if (state_q == S_RUN) begin
            alu_a = a_q[bit_off +: 8];
            alu_b = b_q[bit_off +: 8];
            case (op_q)
                K_ADD: begin
                    alu_ctrl = (idx_q == '0) ? K_ADD : K_ADDC;
                    alu_cin  = (idx_q == '0) ? 1'b0 : carry_q;
                end
                K_SUB: begin
                    // b_q already holds ~B, so seeding carry with 1 yields A + ~B + 1
                    alu_ctrl = K_ADDC;
                    alu_cin  = (idx_q == '0) ? 1'b1 : carry_q;
                end
                default: begin
                    alu_ctrl = op_q;
                    alu_cin  = 1'b0;
                end
            endcase
        end
    end

    // Next-state: accept in IDLE, collect one result byte per RUN cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
`ifdef WIDE_OP_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    carry_d = 1'b0;
                    if (req_supported) begin
                        op_d    = req_op;
                        a_d     = req_a;
                        b_d     = (req_op == K_SUB) ? ~req_b : req_b;
                        idx_d   = '0;
                        err_d   = 1'b0;
`ifdef WIDE_OP_ZERO_FLAG_EN
                        zero_d  = 1'b1;
`endif
                        state_d = S_RUN;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
`ifdef WIDE_OP_ZERO_FLAG_EN
                        zero_d  = 1'b0;
`endif
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                res_d[bit_off +: 8] = alu_out;
                if (op_is_arith) begin
                    carry_d = alu_cout;
                end
`ifdef WIDE_OP_ZERO_FLAG_EN
                zero_d = zero_q && (alu_out == 8'h00);
`endif
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef WIDE_OP_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
`ifdef WIDE_OP_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_wide_op_sequencer.sv
// tb/tb_wide_op_sequencer.sv - randomized and directed self-checking bench for wide_op_sequencer
module tb_wide_op_sequencer;

    localparam int N = 2;
    localparam int W = 8 * N;

    localparam logic [3:0] K_ADD  = 4'h0;
    localparam logic [3:0] K_ADDC = 4'h1;
    localparam logic [3:0] K_SUB  = 4'h2;
    localparam logic [3:0] K_AND  = 4'h3;
    localparam logic [3:0] K_OR   = 4'h4;
    localparam logic [3:0] K_NEG  = 4'h5;
    localparam logic [3:0] K_SLL  = 4'h6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_cout;
    logic         rsp_err;
    logic         rsp_zero;
    logic [3:0]   alu_ctrl;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [7:0]   alu_out;
    logic         alu_cout;

    typedef struct {
        logic [W-1:0] data;
        logic         cout;
        logic         err;
        logic         zero;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] ctrl_log[$];
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

`ifndef WIDE_OP_ZERO_FLAG_EN
    assign rsp_zero = 1'b0;
`endif

    wide_op_sequencer #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
`ifdef WIDE_OP_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout)
    );

    // 8-bit combinational ALU the sequencer drives
    always_comb begin
        logic [8:0] s;
        s = 9'h000;
        case (alu_ctrl)
            K_ADD:   s = {1'b0, alu_a} + {1'b0, alu_b};
            K_ADDC:  s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            K_AND:   s = {1'b0, alu_a & alu_b};
            K_OR:    s = {1'b0, alu_a | alu_b};
            K_NEG:   s = {1'b0, ~alu_a};
            default: s = 9'h000;
        endcase
        alu_out  = s[7:0];
        alu_cout = s[8];
    end

    function automatic logic supported(input logic [3:0] op);
        return (op == K_ADD) || (op == K_SUB) || (op == K_AND) || (op == K_OR) || (op == K_NEG);
    endfunction

    // Whole-word reference: result and final carry from plain wide arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e.err = 1'b0;
        case (op)
            K_ADD:   s = {1'b0, a} + {1'b0, b};
            K_SUB:   s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            K_AND:   s = {1'b0, a & b};
            K_OR:    s = {1'b0, a | b};
            K_NEG:   s = {1'b0, ~a};
            default: begin s = '0; e.err = 1'b1; end
        endcase
        e.data = s[W-1:0];
        e.cout = s[W];
        e.zero = (e.data == '0) && !e.err;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Record each accepted request's expected response; retire it on the response handshake
    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) exp_q.push_back(model(req_op, req_a, req_b));
        if (rst_n && rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    // Every cycle: a pending response must match the model; an idle ALU drive must be zero
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_request", 1, 0);
                end else begin
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_cout", rsp_cout, exp_q[0].cout);
                    check("rsp_err", rsp_err, exp_q[0].err);
`ifdef WIDE_OP_ZERO_FLAG_EN
                    check("rsp_zero", rsp_zero, exp_q[0].zero);
`endif
                    check("req_ready_in_done", req_ready, 0);
                end
            end else if (req_ready) begin
                check("alu_idle_drive", {alu_ctrl, alu_a, alu_b, alu_cin}, {K_AND, 8'h00, 8'h00, 1'b0});
            end
        end
    end

    task automatic do_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ctrl_log.delete();
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            ctrl_log.push_back(alu_ctrl);
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
    endtask

    task automatic finish_rsp(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after_handshake_idle", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] ops [5];
        logic [3:0] op;
        logic [W-1:0] a, b;
        ops[0] = K_ADD; ops[1] = K_SUB; ops[2] = K_AND; ops[3] = K_OR; ops[4] = K_NEG;

        // Hand-computed pins on the reference model
        check("model_add", {model(K_ADD, 16'h00FF, 16'h0001).cout, model(K_ADD, 16'h00FF, 16'h0001).data}, 17'h00100);
        check("model_sub_borrow", {model(K_SUB, 16'h0000, 16'h0001).cout, model(K_SUB, 16'h0000, 16'h0001).data}, 17'h0FFFF);
        check("model_neg", model(K_NEG, 16'h00FF, 16'h0000).data, 16'hFF00);

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #3;
        check("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err}, '0);
        @(posedge clk); #1; rst_n = 1'b1;
        #1 check("idle_req_ready", req_ready, 1);

        do_req(K_ADD, 16'h00FF, 16'h0001, lat);
        check("add_latency", lat, N);
        check("add_data", rsp_data, 16'h0100);
        check("add_cout", rsp_cout, 0);
        check("add_ctrl0", (ctrl_log.size() > 0) ? ctrl_log[0] : 4'hF, K_ADD);
        check("add_ctrl1", (ctrl_log.size() > 1) ? ctrl_log[1] : 4'hF, K_ADDC);
        finish_rsp(0);

        do_req(K_ADD, 16'hFFFF, 16'h0001, lat);
        check("add_wrap_data", rsp_data, 16'h0000);
        check("add_wrap_cout", rsp_cout, 1);
`ifdef WIDE_OP_ZERO_FLAG_EN
        check("add_wrap_zero", rsp_zero, 1);
`endif
        finish_rsp(1);

        do_req(K_SUB, 16'h0100, 16'h0001, lat);
        check("sub_data", rsp_data, 16'h00FF);
        check("sub_cout", rsp_cout, 1);
        check("sub_ctrl0", (ctrl_log.size() > 0) ? ctrl_log[0] : 4'hF, K_ADDC);
        check("sub_ctrl1", (ctrl_log.size() > 1) ? ctrl_log[1] : 4'hF, K_ADDC);
        finish_rsp(0);

        do_req(K_SUB, 16'h0000, 16'h0001, lat);
        check("sub_borrow", {rsp_cout, rsp_data}, 17'h0FFFF);
        finish_rsp(0);

        do_req(K_AND, 16'hF0F0, 16'h3C3C, lat);
        check("and_result", {rsp_cout, rsp_data}, 17'h03030);
        finish_rsp(0);

        do_req(K_NEG, 16'h00FF, 16'h1234, lat);
        check("neg_result", {rsp_cout, rsp_data}, 17'h0FF00);
        finish_rsp(0);

        do_req(K_SLL, 16'h0001, 16'h0001, lat);
        check("sll_latency", lat, 0);
        check("sll_err", {rsp_err, rsp_data}, 17'h10000);
        repeat (5) begin @(posedge clk); #1; end
        check("sll_held", {rsp_valid, req_ready, rsp_err, rsp_data, rsp_cout}, {2'b10, 1'b1, 16'h0000, 1'b0});
        finish_rsp(0);
        check("err_cleared", rsp_err, 0);

        // Reset in the middle of a RUN, after byte 0 has completed
        req_op = K_ADD; req_a = 16'h1234; req_b = 16'h1111; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrun_reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, rsp_zero}, '0);
        check("midrun_reset_alu", {alu_ctrl, alu_a, alu_b, alu_cin}, {K_AND, 8'h00, 8'h00, 1'b0});
        @(posedge clk); #1; rst_n = 1'b1;
        do_req(K_ADD, 16'h0001, 16'h0001, lat);
        check("post_reset_add", {rsp_cout, rsp_data}, 17'h00002);
        finish_rsp(0);

        // Randomized traffic with random response backpressure
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       begin a = '1; b = 16'h0001; end
                1:       begin a = '0; b = 16'($urandom); end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            do_req(op, a, b, lat);
            check("rand_latency", lat, supported(op) ? N : 0);
            finish_rsp($urandom_range(0, 3));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
